// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline.
// Drives PC / IF/ID / ID/EX control from load-use and taken-branch detection,
// tracks the multi-cycle multiply/divide unit, and keeps saturating stall and
// flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MDU_LAT = 32,  // cycles the MDU stays busy after issue (1..255)
  parameter int unsigned CNT_W   = 32   // performance counter width
) (
  input  logic             clk,
  input  logic             rst,              // asynchronous, active-low

  // Instruction in ID
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_hilo_rd,
  input  logic             id_mdu_op,
  input  logic             id_branch_taken,

  // Instruction in EX
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mdu_start,

  // Pipeline control
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_flush,
  output logic             id_ex_flush,

  // MDU status
  output logic             mdu_busy,
  output logic             mdu_overlap_err,

  // Performance counters
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Counter value loaded on issue; the busy window spans MduReload..0.
  localparam logic [7:0]       MduReload = 8'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } mdu_state_e;

  mdu_state_e       mdu_state_q, mdu_state_d;
  logic [7:0]       mdu_cnt_q, mdu_cnt_d;
  logic             overlap_err_q, overlap_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic rs_hit;
  logic rt_hit;
  logic load_use;
  logic mdu_hazard;
  logic stall;
  logic branch_flush;

  assign mdu_busy        = (mdu_state_q == StBusy);
  assign mdu_overlap_err = overlap_err_q;
  assign stall_count     = stall_cnt_q;
  assign flush_count     = flush_cnt_q;

  // Hazard detection; a load targeting $0 never produces a dependency.
  always_comb begin
    rs_hit     = id_uses_rs && (ex_rt == id_rs);
    rt_hit     = id_uses_rt && (ex_rt == id_rt);
    load_use   = ex_mem_read && (ex_rt != 5'd0) && (rs_hit || rt_hit);
    mdu_hazard = mdu_busy && (id_hilo_rd || id_mdu_op);
    // Nothing stalls or flushes while reset is held.
    stall        = rst && (load_use || mdu_hazard);
    branch_flush = rst && id_branch_taken && !stall;
  end

  // Pipeline control: reset > stall > branch > normal. A branch seen during a
  // stall is dropped because its operands may be stale; it resolves again later.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_flush    = 1'b0;
    id_ex_flush = 1'b0;
    if (stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (branch_flush) begin
      if_flush    = 1'b1;
    end
  end

  // MDU busy FSM next state. An issue on the final busy cycle is a clean
  // back-to-back op; an issue any earlier overlaps a running op.
  always_comb begin
    mdu_state_d   = mdu_state_q;
    mdu_cnt_d     = mdu_cnt_q;
    overlap_err_d = overlap_err_q;
    unique case (mdu_state_q)
      StIdle: begin
        if (ex_mdu_start) begin
          mdu_state_d = StBusy;
          mdu_cnt_d   = MduReload;
        end
      end
      StBusy: begin
        if (mdu_cnt_q == 8'd0) begin
          if (ex_mdu_start) begin
            mdu_cnt_d   = MduReload;
          end else begin
            mdu_state_d = StIdle;
          end
        end else if (ex_mdu_start) begin
          mdu_cnt_d     = MduReload;
          overlap_err_d = 1'b1;
        end else begin
          mdu_cnt_d     = mdu_cnt_q - 8'd1;
        end
      end
      default: begin
        mdu_state_d = StIdle;
        mdu_cnt_d   = 8'd0;
      end
    endcase
  end

  // Saturating performance counter next state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
    if (if_flush && (flush_cnt_q != CntMax)) begin
      flush_cnt_d = flush_cnt_q + CntOne;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdu_state_q   <= StIdle;
      mdu_cnt_q     <= 8'd0;
      overlap_err_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      mdu_state_q   <= mdu_state_d;
      mdu_cnt_q     <= mdu_cnt_d;
      overlap_err_q <= overlap_err_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Produces the control inputs of the IF/ID pipeline register and the PC:
  - pc_write: PC update enable.
  - if_id_write: IF/ID update (hold) enable.
  - if_flush: IF/ID flush to NOP.
  - id_ex_flush: bubble insertion into ID/EX.
- Detects load-use hazards and taken branches resolved in ID.
- Tracks a multi-cycle multiply/divide unit with an internal busy FSM, and stalls HI/LO readers and back-to-back MDU ops.
- Keeps saturating stall and flush performance counters.

Parameters:
MDU_LAT, 32, cycles the MDU is busy after issue (legal range 1..255)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_hilo_rd  in  1  ID instruction is mfhi/mflo
id_mdu_op  in  1  ID instruction is mult/multu/div/divu
id_branch_taken  in  1  branch/jump in ID resolved taken this cycle
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  5  destination rt of the load in EX
ex_mdu_start  in  1  MDU op entered EX this cycle (1-cycle pulse)
pc_write  out  1  1 = PC updates
if_id_write  out  1  1 = IF/ID captures, 0 = holds
if_flush  out  1  1 = IF/ID loads NOP at next edge
id_ex_flush  out  1  1 = ID/EX loads bubble at next edge
mdu_busy  out  1  MDU FSM in BUSY
mdu_overlap_err  out  1  sticky: ex_mdu_start seen while BUSY
stall_count  out  CNT_W  cycles with stall asserted, saturating
flush_count  out  CNT_W  cycles with if_flush asserted, saturating

Behaviour:
- Control outputs (pc_write, if_id_write, if_flush, id_ex_flush) are combinational from the current inputs and registered state, so they act at the same edge.
- Hazard terms:
  - load_use = ex_mem_read & (ex_rt != 0) & ((id_uses_rs & ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
  - mdu_hazard = mdu_busy & (id_hilo_rd | id_mdu_op).
  - stall = load_use | mdu_hazard.
- Priority is rst > stall > branch > normal:
  - stall: pc_write=0, if_id_write=0, id_ex_flush=1, if_flush=0. id_branch_taken is ignored because its operands may be stale; the branch is re-evaluated after the stall.
  - branch (id_branch_taken & !stall): pc_write=1, if_id_write=1, if_flush=1, id_ex_flush=0.
  - normal: pc_write=1, if_id_write=1, if_flush=0, id_ex_flush=0.
- A load writing $0 (ex_rt == 0) never stalls.
- MDU FSM, states IDLE and BUSY, with an 8-bit counter mdu_cnt:
  - IDLE, ex_mdu_start=1: go to BUSY, mdu_cnt <= MDU_LAT-1.
  - BUSY, mdu_cnt != 0: mdu_cnt decrements by 1.
  - BUSY, mdu_cnt == 0: go to IDLE. An ex_mdu_start in that same cycle goes to BUSY again with a reload instead.
  - BUSY, ex_mdu_start=1 with mdu_cnt != 0: reload mdu_cnt <= MDU_LAT-1 and set mdu_overlap_err=1 (sticky until reset).
  - mdu_busy = (state == BUSY). It is high for exactly MDU_LAT cycles after the issue edge.
  - MDU_LAT=1: BUSY for one cycle, then IDLE.
- Counters:
  - stall_count increments on each clock edge where stall=1.
  - flush_count increments on each clock edge where if_flush=1.
  - Both saturate at all-ones with no wrap.
- Reset (rst=0, asynchronous, any time including mid-BUSY):
  - state=IDLE, mdu_cnt=0, mdu_overlap_err=0, stall_count=0, flush_count=0.
  - Control outputs evaluate to pc_write=1, if_id_write=1, if_flush=0, id_ex_flush=0, mdu_busy=0.
- Release of rst is sampled at the next rising clk edge. No state changes while rst=0.

Test Plan:
- Load-use stall:
  - Stimulus: ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1.
  - Response: pc_write=0, if_id_write=0, id_ex_flush=1 for 1 cycle. stall_count increments by 1. Outputs return to normal when ex_mem_read drops next cycle.
- $0 and unused operand:
  - Stimulus: ex_rt=0 with id_rs=0; separately ex_rt=9, id_rt=9, id_uses_rt=0.
  - Response: no stall in either case.
- Branch vs stall priority:
  - Stimulus: id_branch_taken=1 together with a load-use hit.
  - Response: stall outputs only, if_flush=0.
  - Stimulus: next cycle, hazard cleared and branch still taken.
  - Response: if_flush=1, flush_count=1.
- MDU busy window, MDU_LAT=4:
  - Stimulus: pulse ex_mdu_start, then hold id_hilo_rd=1.
  - Response: mdu_busy=1 and stall=1 for exactly 4 cycles, then pc_write=1. mdu_overlap_err stays 0.
- MDU overlap and back-to-back:
  - Stimulus: ex_mdu_start again at mdu_cnt=2.
  - Response: counter reloads to 3, mdu_overlap_err=1 and stays 1.
  - Stimulus: ex_mdu_start exactly at mdu_cnt==0.
  - Response: stays BUSY, mdu_overlap_err unchanged.
- Asynchronous reset mid-BUSY:
  - Stimulus: drop rst between clock edges with CNT_W=4 and stall_count=15.
  - Response: mdu_busy=0 and counters=0 immediately, without a clock edge.
  - Before reset: confirm stall_count saturated at 15, with no wrap, after more than 15 stall cycles.
